// File: rtl/sparsity_flag_scheduler.sv
// Ping-pong scheduler for the two sparsity-flag banks in front of the PE row
// engine. The DMA stream fills one bank while the PE drains the other. Each
// flag word is read from RAM, presented to the PE one cycle later with
// pe_start, and the scheduler then holds until row_cal_done. Banks are
// released per tile, and a layer_done pulse closes the layer.
module sparsity_flag_scheduler #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int TILE_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH:0]       cfg_tile_words,
  input  logic [TILE_CNT_WIDTH-1:0] cfg_num_tiles,
  input  logic                      dma_valid,
  input  logic [DATA_WIDTH-1:0]     dma_data,
  output logic                      dma_ready,
  output logic [1:0]                bank_wr_req,
  output logic [ADDR_WIDTH-1:0]     bank_wr_addr,
  output logic [DATA_WIDTH-1:0]     bank_wr_data,
  output logic [1:0]                bank_rd_req,
  output logic [ADDR_WIDTH-1:0]     bank_rd_addr,
  output logic                      bank_sel,
  output logic                      pe_start,
  input  logic                      row_cal_done,
  output logic                      busy,
  output logic                      layer_done
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_LAUNCH,
    S_COMPUTE,
    S_DONE
  } state_t;

  // Latched layer configuration; tile length is kept as a last-word index
  // so both counters compare against it directly.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     last_word;
    logic [TILE_CNT_WIDTH-1:0] num_tiles;
  } cfg_t;

  state_t                    state;
  cfg_t                      cfg;
  cfg_t                      cfg_in;
  logic [ADDR_WIDTH:0]       words_clamped;

  logic [1:0]                full;
  logic                      wr_bank;
  logic                      rd_bank;
  logic [ADDR_WIDTH-1:0]     wr_cnt;
  logic [ADDR_WIDTH-1:0]     rd_cnt;
  logic [TILE_CNT_WIDTH-1:0] tiles_loaded;
  logic [TILE_CNT_WIDTH-1:0] tiles_done;

  logic                      start_ok;
  logic                      wr_fire;
  logic                      wr_tile_end;
  logic                      rd_word_done;
  logic                      rd_tile_end;

  function automatic logic [1:0] bank_onehot(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  // Clamp requested tile length into 1..DEPTH before latching.
  always_comb begin
    words_clamped = cfg_tile_words;
    if (cfg_tile_words == '0)
      words_clamped = (ADDR_WIDTH+1)'(1);
    else if (cfg_tile_words > DEPTH)
      words_clamped = DEPTH;
    cfg_in.last_word = ADDR_WIDTH'(words_clamped - (ADDR_WIDTH+1)'(1));
    cfg_in.num_tiles = cfg_num_tiles;
  end

  // A start is only honoured from IDLE; while busy it is dropped.
  assign start_ok     = start && (state == S_IDLE);
  // Never offer a word into a bank the PE still owns, nor beyond the layer.
  assign dma_ready    = busy && !full[wr_bank] && (tiles_loaded < cfg.num_tiles);
  assign wr_fire      = dma_valid && dma_ready;
  assign wr_tile_end  = wr_fire && (wr_cnt == cfg.last_word);
  // row_cal_done only counts while a word is actually in flight at the PE.
  assign rd_word_done = (state == S_COMPUTE) && row_cal_done;
  assign rd_tile_end  = rd_word_done && (rd_cnt == cfg.last_word);

  // Capture layer configuration on an accepted start.
  always_ff @(posedge clk) begin
    if (reset)
      cfg <= '0;
    else if (start_ok)
      cfg <= cfg_in;
  end

  // Write side: register the DMA word into the current fill bank, advance
  // the word counter and hop banks at the end of each tile.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_wr_req  <= '0;
      bank_wr_addr <= '0;
      bank_wr_data <= '0;
      wr_cnt       <= '0;
      wr_bank      <= 1'b0;
      tiles_loaded <= '0;
    end else begin
      bank_wr_req <= '0;
      if (start_ok) begin
        wr_cnt       <= '0;
        wr_bank      <= 1'b0;
        tiles_loaded <= '0;
      end else if (wr_fire) begin
        bank_wr_req  <= bank_onehot(wr_bank);
        bank_wr_addr <= wr_cnt;
        bank_wr_data <= dma_data;
        if (wr_tile_end) begin
          wr_cnt       <= '0;
          wr_bank      <= ~wr_bank;
          tiles_loaded <= tiles_loaded + TILE_CNT_WIDTH'(1);
        end else begin
          wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Bank ownership: a completed fill marks its bank full, a completed tile
  // on the read side frees its bank. They always hit opposite banks, so
  // both updates may land in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      full <= '0;
    end else begin
      if (wr_tile_end) full[wr_bank] <= 1'b1;
      if (rd_tile_end) full[rd_bank] <= 1'b0;
    end
  end

  // Read FSM: WAIT for a full bank, READ one word, LAUNCH the PE one cycle
  // later to match RAM latency, then hold in COMPUTE until the PE reports.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      layer_done   <= 1'b0;
      pe_start     <= 1'b0;
      bank_rd_req  <= '0;
      bank_rd_addr <= '0;
      bank_sel     <= 1'b0;
      rd_bank      <= 1'b0;
      rd_cnt       <= '0;
      tiles_done   <= '0;
    end else begin
      pe_start    <= 1'b0;
      bank_rd_req <= '0;
      layer_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            rd_bank    <= 1'b0;
            rd_cnt     <= '0;
            tiles_done <= '0;
            state      <= (cfg_num_tiles == '0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (full[rd_bank]) begin
            bank_rd_req  <= bank_onehot(rd_bank);
            bank_rd_addr <= rd_cnt;
            bank_sel     <= rd_bank;
            state        <= S_READ;
          end
        end
        S_READ: begin
          pe_start <= 1'b1;
          state    <= S_LAUNCH;
        end
        S_LAUNCH: begin
          state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (rd_word_done) begin
            if (!rd_tile_end) begin
              rd_cnt       <= rd_cnt + ADDR_WIDTH'(1);
              bank_rd_req  <= bank_onehot(rd_bank);
              bank_rd_addr <= rd_cnt + ADDR_WIDTH'(1);
              bank_sel     <= rd_bank;
              state        <= S_READ;
            end else begin
              rd_cnt     <= '0;
              rd_bank    <= ~rd_bank;
              tiles_done <= tiles_done + TILE_CNT_WIDTH'(1);
              if ((tiles_done + TILE_CNT_WIDTH'(1)) == cfg.num_tiles)
                state <= S_DONE;
              else
                state <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          layer_done <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
